decode_ctrl: RTL and testbench
==============================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have no parameters; widths are fixed; scoreboard_entry_t comes from ariane_pkg.
REQ-002 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: flush_i  in  1  pipeline flush.
REQ-005 SHALL have port: fetch_valid_i  in  1  fetch entry valid.
REQ-006 SHALL have port: fetch_ready_o  out  1  entry accepted this cycle when high with fetch_valid_i.
REQ-007 SHALL have port: fetch_pc_i  in  64  entry PC; fetch_instr_i  in  32  instruction; fetch_is_compressed_i  in  1  compressed flag.
REQ-008 SHALL have port: dec_pc_o  out  64, dec_instr_o  out  32, dec_is_compressed_o  out  1  combinational pass-through of the fetch fields to the decoder.
REQ-009 SHALL have port: dec_entry_i  in  scoreboard_entry_t  decoder result; dec_is_cf_i  in  1  decoder control-flow flag.
REQ-010 SHALL have port: issue_valid_o  out  1; issue_ready_i  in  1; issue_entry_o  out  scoreboard_entry_t  registered decoded entry.
REQ-011 SHALL have port: resolve_valid_i  in  1  control-flow resolution; resolve_mispredict_i  in  1  resolution was a mispredict.
REQ-012 SHALL have port: redirect_o  out  1  one-cycle pulse on a mispredicted resolution.
REQ-013 SHALL have port: cf_pending_o  out  1  high when state is not RUN; stall_cnt_o  out  16  saturating count of control-flow stall cycles.

Function
REQ-014 SHALL implement states RUN, CF_ISSUE (control-flow entry held in the issue register) and CF_WAIT (control-flow entry issued, awaiting resolution).
REQ-015 SHALL drive fetch_ready_o = (state==RUN) && !flush_i && (!issue_valid_o || issue_ready_i), combinationally.
REQ-016 SHALL, on accept (fetch_valid_i && fetch_ready_o), load issue_entry_o <= dec_entry_i and set issue_valid_o <= 1 (decode-to-issue latency 1 cycle).
REQ-017 SHALL, on issue handshake (issue_valid_o && issue_ready_i) with no accept in the same cycle, clear issue_valid_o; accept plus issue in the same cycle SHALL keep issue_valid_o=1 with the new entry (back-to-back, 1 instr/cycle).
REQ-018 SHALL hold issue_entry_o stable while issue_valid_o && !issue_ready_i.
REQ-019 SHALL transition RUN->CF_ISSUE on an accept with dec_is_cf_i=1.
REQ-020 SHALL transition CF_ISSUE->CF_WAIT on the issue handshake of the control-flow entry.
REQ-021 SHALL transition CF_WAIT->RUN on resolve_valid_i; fetch_ready_o SHALL be able to rise in the following cycle.
REQ-022 SHALL ignore resolve_valid_i in RUN and CF_ISSUE (no state change, no redirect).
REQ-023 SHALL pulse redirect_o=1 for exactly the cycle after resolve_valid_i && resolve_mispredict_i is sampled in CF_WAIT, and keep it 0 otherwise.
REQ-024 SHALL increment stall_cnt_o by 1 on every cycle in CF_ISSUE or CF_WAIT, saturating at 16'hFFFF; the counter SHALL NOT wrap and SHALL NOT be cleared by flush_i.
REQ-025 SHALL give flush_i highest priority: next cycle issue_valid_o=0 and state=RUN, with no accept during flush and any same-cycle resolve discarded (redirect_o=0).
REQ-026 SHALL drive cf_pending_o = (state != RUN), registered-state based.

Reset
REQ-027 SHALL, while rst_ni=0 and asynchronously, force state=RUN, issue_valid_o=0, issue_entry_o='0, redirect_o=0 and stall_cnt_o=0.
REQ-028 SHALL, on reset assertion mid-operation (any state), discard the pending entry and pending resolution; the first accept is possible on the first clock edge after deassertion.

Verification
REQ-029 SHALL cover: stream of 4 non-CF entries, issue_ready_i=1 -> 4 entries on issue_entry_o on consecutive cycles, each 1 cycle after accept, fetch_ready_o continuously 1.
REQ-030 SHALL cover: issue_ready_i=0 for 3 cycles with issue_valid_o=1 -> fetch_ready_o=0 and issue_entry_o unchanged for those 3 cycles.
REQ-031 SHALL cover: CF entry accepted at PC 0x8000_0010, issued 2 cycles later, resolve (no mispredict) 3 cycles after that -> fetch_ready_o=0 for 5 cycles, stall_cnt_o=5, redirect_o stays 0.
REQ-032 SHALL cover: resolve with mispredict in CF_WAIT -> redirect_o=1 for exactly 1 cycle, then state=RUN; a resolve pulse in RUN -> no effect.
REQ-033 SHALL cover: flush_i in CF_ISSUE with issue_valid_o=1 -> next cycle issue_valid_o=0, cf_pending_o=0, stall_cnt_o kept; stall_cnt_o preloaded to 0xFFFE with 3 further stall cycles -> 0xFFFF.
REQ-034 SHALL cover: rst_ni low asynchronously in CF_WAIT -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_ctrl.sv
// Decode-to-issue control: one-entry issue register, control-flow stall FSM,
// mispredict redirect pulse and a saturating stall-cycle counter.
package ariane_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_compressed;
    logic        valid;
  } scoreboard_entry_t;
endpackage

module decode_ctrl
  import ariane_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [63:0]       fetch_pc_i,
  input  logic [31:0]       fetch_instr_i,
  input  logic              fetch_is_compressed_i,
  output logic [63:0]       dec_pc_o,
  output logic [31:0]       dec_instr_o,
  output logic              dec_is_compressed_o,
  input  scoreboard_entry_t dec_entry_i,
  input  logic              dec_is_cf_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output scoreboard_entry_t issue_entry_o,
  input  logic              resolve_valid_i,
  input  logic              resolve_mispredict_i,
  output logic              redirect_o,
  output logic              cf_pending_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CF_ISSUE = 2'd1,
    CF_WAIT  = 2'd2
  } state_e;

  state_e            state_r, state_s;
  logic              issue_valid_r, issue_valid_s;
  scoreboard_entry_t issue_entry_r, issue_entry_s;
  logic              redirect_r, redirect_s;
  logic [15:0]       stall_cnt_r, stall_cnt_s;
  logic              accept_s;
  logic              issue_hs_s;

  assign dec_pc_o            = fetch_pc_i;
  assign dec_instr_o         = fetch_instr_i;
  assign dec_is_compressed_o = fetch_is_compressed_i;

  // A new entry may enter only when no control-flow op is outstanding and the slot frees up.
  assign fetch_ready_o = (state_r == RUN) && !flush_i && (!issue_valid_r || issue_ready_i);
  assign accept_s      = fetch_valid_i && fetch_ready_o;
  assign issue_hs_s    = issue_valid_r && issue_ready_i;

  assign issue_valid_o = issue_valid_r;
  assign issue_entry_o = issue_entry_r;
  assign redirect_o    = redirect_r;
  assign cf_pending_o  = (state_r != RUN);
  assign stall_cnt_o   = stall_cnt_r;

  // Next-state, issue register and counter update; flush overrides everything but the counter.
  always_comb begin
    state_s       = state_r;
    issue_valid_s = issue_valid_r;
    issue_entry_s = issue_entry_r;
    redirect_s    = 1'b0;
    stall_cnt_s   = stall_cnt_r;

    if ((state_r != RUN) && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_s = stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_s = stall_cnt_r;
    end

    if (flush_i) begin
      state_s       = RUN;
      issue_valid_s = 1'b0;
    end else begin
      if (accept_s) begin
        issue_valid_s = 1'b1;
        issue_entry_s = dec_entry_i;
      end else if (issue_hs_s) begin
        issue_valid_s = 1'b0;
      end else begin
        issue_valid_s = issue_valid_r;
      end

      case (state_r)
        RUN: begin
          if (accept_s && dec_is_cf_i) state_s = CF_ISSUE;
          else                         state_s = RUN;
        end
        CF_ISSUE: begin
          if (issue_hs_s) state_s = CF_WAIT;
          else            state_s = CF_ISSUE;
        end
        CF_WAIT: begin
          if (resolve_valid_i) begin
            state_s    = RUN;
            redirect_s = resolve_mispredict_i;
          end else begin
            state_s = CF_WAIT;
          end
        end
        default: state_s = RUN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= RUN;
      issue_valid_r <= 1'b0;
      issue_entry_r <= '0;
      redirect_r    <= 1'b0;
      stall_cnt_r   <= 16'd0;
    end else begin
      state_r       <= state_s;
      issue_valid_r <= issue_valid_s;
      issue_entry_r <= issue_entry_s;
      redirect_r    <= redirect_s;
      stall_cnt_r   <= stall_cnt_s;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios plus random traffic,
// compared against a slot/outstanding-branch model of the intended behaviour.
module tb_decode_ctrl;
  import ariane_pkg::*;

  localparam int ENTRY_W = $bits(scoreboard_entry_t);

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              fetch_valid_i;
  logic              fetch_ready_o;
  logic [63:0]       fetch_pc_i;
  logic [31:0]       fetch_instr_i;
  logic              fetch_is_compressed_i;
  logic [63:0]       dec_pc_o;
  logic [31:0]       dec_instr_o;
  logic              dec_is_compressed_o;
  scoreboard_entry_t dec_entry_i;
  logic              dec_is_cf_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  scoreboard_entry_t issue_entry_o;
  logic              resolve_valid_i;
  logic              resolve_mispredict_i;
  logic              redirect_o;
  logic              cf_pending_o;
  logic [15:0]       stall_cnt_o;

  decode_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
    .fetch_is_compressed_i(fetch_is_compressed_i),
    .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
    .dec_is_compressed_o(dec_is_compressed_o),
    .dec_entry_i(dec_entry_i), .dec_is_cf_i(dec_is_cf_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_entry_o(issue_entry_o),
    .resolve_valid_i(resolve_valid_i), .resolve_mispredict_i(resolve_mispredict_i),
    .redirect_o(redirect_o), .cf_pending_o(cf_pending_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: the issue slot, whether it holds a branch, and whether a
  // branch has left and is awaiting its resolution.
  scoreboard_entry_t m_slot;
  bit                m_slot_v;
  bit                m_cf_in_slot;
  bit                m_waiting;
  bit                m_redirect;
  int                m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pending();
    return m_cf_in_slot || m_waiting;
  endfunction

  task automatic model_reset();
    m_slot       = '0;
    m_slot_v     = 1'b0;
    m_cf_in_slot = 1'b0;
    m_waiting    = 1'b0;
    m_redirect   = 1'b0;
    m_stall      = 0;
  endtask

  task automatic check_regs();
    chk("issue_valid", 128'(issue_valid_o), 128'(m_slot_v));
    if (m_slot_v) chk("issue_entry", 128'(issue_entry_o), 128'(m_slot));
    chk("redirect", 128'(redirect_o), 128'(m_redirect));
    chk("cf_pending", 128'(cf_pending_o), 128'(m_pending()));
    chk("stall_cnt", 128'(stall_cnt_o), 128'(m_stall));
  endtask

  task automatic new_fetch(input bit valid, input bit is_cf, input logic [63:0] pc);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    fetch_valid_i         = valid;
    fetch_pc_i            = pc;
    fetch_instr_i         = $urandom();
    fetch_is_compressed_i = 1'($urandom_range(1));
    dec_entry_i           = scoreboard_entry_t'(r[ENTRY_W-1:0]);
    dec_entry_i.pc        = pc;
    dec_is_cf_i           = is_cf;
  endtask

  // One cycle: inputs are already applied; check combinational outputs, advance
  // the model, clock, then check registered outputs.
  task automatic step();
    bit ready, acc, iss;
    #1;
    ready = !m_pending() && !flush_i && (!m_slot_v || issue_ready_i);
    chk("fetch_ready", 128'(fetch_ready_o), 128'(ready));
    chk("dec_pc", 128'(dec_pc_o), 128'(fetch_pc_i));
    chk("dec_instr", 128'({dec_is_compressed_o, dec_instr_o}),
        128'({fetch_is_compressed_i, fetch_instr_i}));
    acc = fetch_valid_i && ready;
    iss = m_slot_v && issue_ready_i;
    if (m_pending() && m_stall < 65535) m_stall++;
    m_redirect = !flush_i && m_waiting && resolve_valid_i && resolve_mispredict_i;
    if (flush_i) begin
      m_slot_v     = 1'b0;
      m_cf_in_slot = 1'b0;
      m_waiting    = 1'b0;
    end else begin
      if (m_waiting && resolve_valid_i) m_waiting = 1'b0;
      if (iss) begin
        m_slot_v = 1'b0;
        if (m_cf_in_slot) begin
          m_cf_in_slot = 1'b0;
          m_waiting    = 1'b1;
        end
      end
      if (acc) begin
        m_slot_v     = 1'b1;
        m_slot       = dec_entry_i;
        m_cf_in_slot = dec_is_cf_i;
      end
    end
    @(posedge clk_i);
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    flush_i              = 1'b0;
    resolve_valid_i      = 1'b0;
    resolve_mispredict_i = 1'b0;
    new_fetch(1'b0, 1'b0, 64'(2 * $urandom()));
  endtask

  initial begin
    int guard;
    // Reset values are visible asynchronously, before any clock edge.
    rst_ni        = 1'b0;
    issue_ready_i = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check_regs();
    chk("reset_entry", 128'(issue_entry_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Four back-to-back non-branch entries.
    for (int i = 0; i < 4; i++) begin
      new_fetch(1'b1, 1'b0, 64'h8000_0000 + 64'(4 * i));
      step();
      chk("stream_entry_pc", 128'(issue_entry_o.pc), 128'(64'h8000_0000 + 64'(4 * i)));
    end

    // Issue back-pressure for three cycles with fetch still offering entries.
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      new_fetch(1'b1, 1'b0, 64'h9000_0000 + 64'(4 * i));
      step();
      chk("hold_entry_pc", 128'(issue_entry_o.pc), 128'(64'h8000_000C));
    end
    issue_ready_i = 1'b1;
    idle_inputs();
    step();

    // Branch at 0x8000_0010: issued two cycles after accept, resolved three later.
    new_fetch(1'b1, 1'b1, 64'h8000_0010);
    step();
    idle_inputs();
    issue_ready_i = 1'b0;
    step();
    issue_ready_i = 1'b1;
    step();
    step();
    step();
    resolve_valid_i = 1'b1;
    step();
    chk("cf_stall_5", 128'(stall_cnt_o), 128'(16'd5));
    chk("cf_no_redirect", 128'(redirect_o), 128'(1'b0));
    idle_inputs();
    new_fetch(1'b1, 1'b0, 64'h8000_0014);
    step();

    // Mispredicted resolution, then a stray resolve while running.
    new_fetch(1'b1, 1'b1, 64'h8000_0020);
    step();
    idle_inputs();
    step();
    resolve_valid_i      = 1'b1;
    resolve_mispredict_i = 1'b1;
    step();
    chk("mispredict_redirect", 128'(redirect_o), 128'(1'b1));
    idle_inputs();
    step();
    chk("redirect_one_cycle", 128'(redirect_o), 128'(1'b0));
    resolve_valid_i      = 1'b1;
    resolve_mispredict_i = 1'b1;
    step();
    chk("resolve_in_run", 128'(redirect_o), 128'(1'b0));

    // Flush while a branch sits in the issue register.
    new_fetch(1'b1, 1'b1, 64'h8000_0040);
    resolve_valid_i = 1'b0;
    issue_ready_i   = 1'b0;
    step();
    idle_inputs();
    flush_i = 1'b1;
    step();
    chk("flush_valid", 128'(issue_valid_o), 128'(1'b0));
    chk("flush_pending", 128'(cf_pending_o), 128'(1'b0));
    issue_ready_i = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      new_fetch(($urandom_range(3) != 0), ($urandom_range(4) == 0), 64'(2 * $urandom()));
      issue_ready_i        = ($urandom_range(3) != 0);
      resolve_valid_i      = ($urandom_range(2) == 0);
      resolve_mispredict_i = 1'($urandom_range(1));
      flush_i              = ($urandom_range(19) == 0);
      step();
    end

    // Park a branch in the wait state and drive the counter to saturation.
    idle_inputs();
    issue_ready_i = 1'b1;
    flush_i       = 1'b1;
    step();
    flush_i = 1'b0;
    new_fetch(1'b1, 1'b1, 64'h8000_0080);
    step();
    idle_inputs();
    guard = 0;
    while (m_stall < 16'hFFFE && guard < 70000) begin
      step();
      guard++;
    end
    chk("sat_preload", 128'(stall_cnt_o), 128'(16'hFFFE));
    for (int i = 0; i < 3; i++) step();
    chk("sat_max", 128'(stall_cnt_o), 128'(16'hFFFF));
    step();
    chk("sat_no_wrap", 128'(stall_cnt_o), 128'(16'hFFFF));

    // Asynchronous reset while waiting for resolution.
    resolve_valid_i      = 1'b1;
    resolve_mispredict_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_regs();
    chk("async_entry", 128'(issue_entry_o), 128'(0));
    chk("async_fetch_ready", 128'(fetch_ready_o), 128'(1'b1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();
    new_fetch(1'b1, 1'b0, 64'h8000_0100);
    step();
    chk("first_accept", 128'(issue_valid_o), 128'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
